svc_rv_hazard: RTL and testbench

Hazard controller for the 5-stage RV pipeline. It consumes the EX-side control outputs of the ID/EX register plus MEM/WB destination info and the data-memory read handshake. It drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It contains a memory-wait FSM and saturating performance counters.

---
 rtl/svc_rv_hazard.sv | 158 +++++++++++++++
 tb/tb_svc_rv_hazard.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_hazard.sv
// Hazard controller for the 5-stage RV pipeline: load-use / RAW stalls, redirect
// flushes, a memory-wait freeze FSM and saturating performance counters.
module svc_rv_hazard #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             reg_write_ex,
  input  logic [2:0]       res_src_ex,
  input  logic [4:0]       rd_mem,
  input  logic             reg_write_mem,
  input  logic [4:0]       rd_wb,
  input  logic             reg_write_wb,
  input  logic             redirect_ex,
  input  logic             dmem_rd_mem,
  input  logic             dmem_rd_valid,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall_back,
  output logic             flush_mem_wb,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] RES_MEM = 3'b001;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             mem_wait_s;
  logic             raw_ex_s, raw_mem_s, raw_wb_s, load_use_s;
  logic             lu_evt_s, flush_evt_s;
  logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;
  logic [CNT_W-1:0] mem_wait_cnt_q, mem_wait_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // x0 is hardwired to zero, so a write to it can never create a dependency.
  function automatic logic src_hit(input logic [4:0] rd, input logic we);
    src_hit = we && (rd != 5'd0) &&
              ((uses_rs1_id && (rs1_id == rd)) || (uses_rs2_id && (rs2_id == rd)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    if (en && (c != {CNT_W{1'b1}})) begin
      sat_inc = c + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = c;
    end
  endfunction

  // Memory-wait FSM next state and freeze condition.
  always_comb begin
    state_d    = state_q;
    mem_wait_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dmem_rd_mem && !dmem_rd_valid) begin
          mem_wait_s = 1'b1;
          state_d    = ST_MEM_WAIT;
        end else begin
          state_d    = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_rd_valid) begin
          mem_wait_s = 1'b1;
          state_d    = ST_MEM_WAIT;
        end else begin
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Dependency detection against the three producer stages.
  always_comb begin
    raw_ex_s  = src_hit(rd_ex, reg_write_ex);
    raw_mem_s = src_hit(rd_mem, reg_write_mem);
    raw_wb_s  = src_hit(rd_wb, reg_write_wb);
    if (FWD_EN) begin
      load_use_s = raw_ex_s && (res_src_ex == RES_MEM);
    end else begin
      load_use_s = raw_ex_s || raw_mem_s || raw_wb_s;
    end
  end

  // Stall/flush priority: memory freeze, then redirect, then load-use.
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    stall_back   = 1'b0;
    flush_mem_wb = 1'b0;
    lu_evt_s     = 1'b0;
    flush_evt_s  = 1'b0;
    if (mem_wait_s) begin
      // EX is held, so a pending redirect stays visible until the freeze ends.
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_back   = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (redirect_ex) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      flush_evt_s = 1'b1;
    end else if (load_use_s) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
      lu_evt_s    = 1'b1;
    end else begin
      lu_evt_s    = 1'b0;
    end
  end

  // Saturating counter next values.
  always_comb begin
    load_use_cnt_d = sat_inc(load_use_cnt_q, lu_evt_s);
    mem_wait_cnt_d = sat_inc(mem_wait_cnt_q, mem_wait_s);
    flush_cnt_d    = sat_inc(flush_cnt_q, flush_evt_s);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      load_use_cnt_q <= {CNT_W{1'b0}};
      mem_wait_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      load_use_cnt_q <= load_use_cnt_d;
      mem_wait_cnt_q <= mem_wait_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign load_use_cnt = load_use_cnt_q;
  assign mem_wait_cnt = mem_wait_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_svc_rv_hazard.sv
// Bench for svc_rv_hazard: a forwarding instance and a no-forwarding 4-bit-counter
// instance share stimulus and are checked against a rule-level reference model.
module tb_svc_rv_hazard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex, rd_mem, rd_wb;
  logic       uses_rs1_id, uses_rs2_id, reg_write_ex, reg_write_mem, reg_write_wb;
  logic [2:0] res_src_ex;
  logic       redirect_ex, dmem_rd_mem, dmem_rd_valid;

  logic        o0_stall_pc, o0_stall_if_id, o0_flush_if_id, o0_flush_id_ex, o0_stall_back, o0_flush_mem_wb;
  logic        o1_stall_pc, o1_stall_if_id, o1_flush_if_id, o1_flush_id_ex, o1_stall_back, o1_flush_mem_wb;
  logic [31:0] c0_lu, c0_mw, c0_fl;
  logic [3:0]  c1_lu, c1_mw, c1_fl;
  logic [5:0]  o0, o1;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_wait;
  int unsigned m0_lu, m0_mw, m0_fl, m1_lu, m1_mw, m1_fl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rdex;
    logic       weex;
    logic [2:0] res;
    logic [4:0] rdmem;
    logic       wemem;
    logic [4:0] rdwb;
    logic       wewb;
    logic       redir;
    logic       drd;
    logic       dval;
    logic [5:0] exp0;
    logic [5:0] exp1;
  } vec_t;

  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_LU   = 6'b110100;
  localparam logic [5:0] E_RED  = 6'b001100;
  localparam logic [5:0] E_MW   = 6'b110011;

  svc_rv_hazard #(.FWD_EN(1'b1), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
    .reg_write_ex(reg_write_ex), .res_src_ex(res_src_ex), .rd_mem(rd_mem),
    .reg_write_mem(reg_write_mem), .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
    .redirect_ex(redirect_ex), .dmem_rd_mem(dmem_rd_mem), .dmem_rd_valid(dmem_rd_valid),
    .stall_pc(o0_stall_pc), .stall_if_id(o0_stall_if_id), .flush_if_id(o0_flush_if_id),
    .flush_id_ex(o0_flush_id_ex), .stall_back(o0_stall_back), .flush_mem_wb(o0_flush_mem_wb),
    .load_use_cnt(c0_lu), .mem_wait_cnt(c0_mw), .flush_cnt(c0_fl)
  );

  svc_rv_hazard #(.FWD_EN(1'b0), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .rd_ex(rd_ex),
    .reg_write_ex(reg_write_ex), .res_src_ex(res_src_ex), .rd_mem(rd_mem),
    .reg_write_mem(reg_write_mem), .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
    .redirect_ex(redirect_ex), .dmem_rd_mem(dmem_rd_mem), .dmem_rd_valid(dmem_rd_valid),
    .stall_pc(o1_stall_pc), .stall_if_id(o1_stall_if_id), .flush_if_id(o1_flush_if_id),
    .flush_id_ex(o1_flush_id_ex), .stall_back(o1_stall_back), .flush_mem_wb(o1_flush_mem_wb),
    .load_use_cnt(c1_lu), .mem_wait_cnt(c1_mw), .flush_cnt(c1_fl)
  );

  assign o0 = {o0_stall_pc, o0_stall_if_id, o0_flush_if_id, o0_flush_id_ex, o0_stall_back, o0_flush_mem_wb};
  assign o1 = {o1_stall_pc, o1_stall_if_id, o1_flush_if_id, o1_flush_id_ex, o1_stall_back, o1_flush_mem_wb};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic [4:0] rdex, input logic weex,
                               input logic [2:0] res, input logic [4:0] rdmem, input logic wemem,
                               input logic [4:0] rdwb, input logic wewb, input logic redir,
                               input logic drd, input logic dval, input logic [5:0] exp0,
                               input logic [5:0] exp1);
    mkv = {rs1, rs2, u1, u2, rdex, weex, res, rdmem, wemem, rdwb, wewb, redir, drd, dval, exp0, exp1};
  endfunction

  task automatic apply(input vec_t v);
    rs1_id = v.rs1; rs2_id = v.rs2; uses_rs1_id = v.u1; uses_rs2_id = v.u2;
    rd_ex = v.rdex; reg_write_ex = v.weex; res_src_ex = v.res;
    rd_mem = v.rdmem; reg_write_mem = v.wemem; rd_wb = v.rdwb; reg_write_wb = v.wewb;
    redirect_ex = v.redir; dmem_rd_mem = v.drd; dmem_rd_valid = v.dval;
  endtask

  task automatic clear_inputs();
    apply(mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE));
  endtask

  function automatic bit hit(input logic [4:0] rd, input logic we);
    return we && rd != 5'd0 &&
           ((uses_rs1_id && rs1_id == rd) || (uses_rs2_id && rs2_id == rd));
  endfunction

  function automatic logic [5:0] expect_out(input bit mw, input bit redir, input bit lu);
    if (mw) return E_MW;
    if (redir) return E_RED;
    if (lu) return E_LU;
    return E_NONE;
  endfunction

  function automatic int unsigned bump(input int unsigned c, input bit en, input int unsigned max);
    return (en && c < max) ? c + 1 : c;
  endfunction

  // Compare both instances against the model for the current cycle, then advance one clock.
  task automatic step();
    bit mw, lu0, lu1, hx;
    #1;
    mw  = !dmem_rd_valid && (m_wait || dmem_rd_mem);
    hx  = hit(rd_ex, reg_write_ex);
    lu0 = hx && res_src_ex == 3'b001;
    lu1 = hx || hit(rd_mem, reg_write_mem) || hit(rd_wb, reg_write_wb);
    chk("out_fwd", o0, expect_out(mw, redirect_ex, lu0));
    chk("out_nofwd", o1, expect_out(mw, redirect_ex, lu1));
    chk("lu_cnt_fwd", c0_lu, m0_lu);
    chk("mw_cnt_fwd", c0_mw, m0_mw);
    chk("fl_cnt_fwd", c0_fl, m0_fl);
    chk("lu_cnt_nofwd", c1_lu, m1_lu);
    chk("mw_cnt_nofwd", c1_mw, m1_mw);
    chk("fl_cnt_nofwd", c1_fl, m1_fl);
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 1'b0;
      m0_lu = 0; m0_mw = 0; m0_fl = 0; m1_lu = 0; m1_mw = 0; m1_fl = 0;
    end else begin
      m_wait = mw;
      m0_lu = bump(m0_lu, !mw && !redirect_ex && lu0, 32'hFFFF_FFFF);
      m1_lu = bump(m1_lu, !mw && !redirect_ex && lu1, 15);
      m0_mw = bump(m0_mw, mw, 32'hFFFF_FFFF);
      m1_mw = bump(m1_mw, mw, 15);
      m0_fl = bump(m0_fl, !mw && redirect_ex, 32'hFFFF_FFFF);
      m1_fl = bump(m1_fl, !mw && redirect_ex, 15);
    end
    @(negedge clk);
  endtask

  vec_t        vecs[11];
  int unsigned snap;

  initial begin
    vecs[0]  = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE);
    vecs[1]  = mkv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 3'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_LU, E_LU);
    vecs[2]  = mkv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, E_LU);
    vecs[3]  = mkv(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 3'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, E_LU);
    vecs[4]  = mkv(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE, E_LU);
    vecs[5]  = mkv(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 3'd1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE);
    vecs[6]  = mkv(5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 3'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE, E_NONE);
    vecs[7]  = mkv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 3'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_RED, E_RED);
    vecs[8]  = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE, E_NONE);
    vecs[9]  = mkv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_RED, E_RED);
    vecs[10] = mkv(5'd3, 5'd12, 1'b1, 1'b1, 5'd12, 1'b1, 3'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_LU, E_LU);

    // reset state
    rst_n = 1'b0;
    clear_inputs();
    m_wait = 1'b0;
    m0_lu = 0; m0_mw = 0; m0_fl = 0; m1_lu = 0; m1_mw = 0; m1_fl = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out_fwd", o0, E_NONE);
    chk("reset_out_nofwd", o1, E_NONE);
    chk("reset_lu_cnt", c0_lu, 32'd0);
    chk("reset_mw_cnt", c0_mw, 32'd0);
    chk("reset_fl_cnt", c0_fl, 32'd0);
    step();

    // single-cycle table from RUN
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d_fwd", i), o0, vecs[i].exp0);
      chk($sformatf("vec%0d_nofwd", i), o1, vecs[i].exp1);
      step();
    end
    clear_inputs();
    step();

    // redirect + load-use: flush counted, load-use not
    snap = m0_lu;
    apply(vecs[7]);
    step();
    clear_inputs();
    #1;
    chk("red_lu_lu_cnt", c0_lu, snap);

    // memory wait, 3 cycles, with and without a held redirect
    for (int r = 0; r < 2; r++) begin
      snap = m0_mw;
      clear_inputs();
      redirect_ex = (r == 1);
      dmem_rd_mem = 1'b1;
      for (int k = 0; k < 3; k++) begin
        #1;
        chk($sformatf("memwait%0d_c%0d", r, k), o0, E_MW);
        step();
        dmem_rd_mem = 1'b0;
      end
      dmem_rd_valid = 1'b1;
      #1;
      chk($sformatf("memwait%0d_valid", r), o0, (r == 1) ? E_RED : E_NONE);
      step();
      clear_inputs();
      #1;
      chk($sformatf("memwait%0d_cnt", r), c0_mw, snap + 3);
      step();
    end

    // reset while in MEM_WAIT
    dmem_rd_mem = 1'b1;
    step();
    dmem_rd_mem = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_mw_out", o0, E_NONE);
    chk("rst_mw_mwcnt", c0_mw, 32'd0);
    chk("rst_mw_flcnt", c1_fl, 32'd0);
    step();

    // counter saturation on the 4-bit instance
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    apply(vecs[1]);
    repeat (20) step();
    clear_inputs();
    #1;
    chk("sat_lu_cnt4", c1_lu, 32'd15);
    chk("sat_lu_cnt32", c0_lu, 32'd20);
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      rs1_id        = 5'($urandom_range(0, 3));
      rs2_id        = 5'($urandom_range(0, 3));
      uses_rs1_id   = 1'($urandom_range(0, 1));
      uses_rs2_id   = 1'($urandom_range(0, 1));
      rd_ex         = 5'($urandom_range(0, 3));
      reg_write_ex  = 1'($urandom_range(0, 1));
      res_src_ex    = 3'($urandom_range(0, 3));
      rd_mem        = 5'($urandom_range(0, 3));
      reg_write_mem = 1'($urandom_range(0, 1));
      rd_wb         = 5'($urandom_range(0, 3));
      reg_write_wb  = 1'($urandom_range(0, 1));
      redirect_ex   = ($urandom_range(0, 5) == 0);
      dmem_rd_mem   = ($urandom_range(0, 3) == 0);
      dmem_rd_valid = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
